// File: rtl/qcm_pauli_pkg.sv
// rtl/qcm_pauli_pkg.sv - Pauli literal encoding, single-qubit anticommute helper, collector state enum
package qcm_pauli_pkg;

    localparam logic [1:0] LIT_I = 2'b00;
    localparam logic [1:0] LIT_Z = 2'b01;
    localparam logic [1:0] LIT_X = 2'b10;
    localparam logic [1:0] LIT_Y = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } collect_state_t;

    // Symplectic product a.x&b.z ^ a.z&b.x, expanded per literal of a
    function automatic logic pauli_anticommute(input logic [1:0] a, input logic [1:0] b);
        logic r;
        case (a)
            LIT_I:   r = 1'b0;
            LIT_X:   r = b[0];
            LIT_Z:   r = b[1];
            LIT_Y:   r = b[0] ^ b[1];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pauli_row_anticommute.sv
// rtl/pauli_row_anticommute.sv - combinational anticommute parity of one Pauli row against a target
module pauli_row_anticommute
    import qcm_pauli_pkg::*;
#(
    parameter int NUM_QUBIT = 4
) (
    input  logic [NUM_QUBIT-1:0][1:0] i_row,
    input  logic [NUM_QUBIT-1:0][1:0] i_target,
    output logic                      o_anticommute
);

    always_comb begin
        o_anticommute = 1'b0;
        for (int q = 0; q < NUM_QUBIT; q++) begin
            o_anticommute = o_anticommute ^ pauli_anticommute(i_row[q], i_target[q]);
        end
    end

endmodule

// File: rtl/anticommute_row_collector.sv
// rtl/anticommute_row_collector.sv - frame collector with per-row anticommute flags; PHASE_TRACK_EN stores row phases
module anticommute_row_collector
    import qcm_pauli_pkg::*;
#(
    parameter int NUM_QUBIT = 4,
    parameter int IDX_W     = (NUM_QUBIT > 1) ? $clog2(NUM_QUBIT) : 1
) (
    input  logic                      clk,
    input  logic                      rst_new,
    input  logic [NUM_QUBIT-1:0][1:0] literals_in,
    input  logic                      phase_in,
    input  logic                      valid_in,
    input  logic                      valid_P,
    input  logic                      ld_flag_anticommute,
    input  logic [NUM_QUBIT-1:0][1:0] pauli_target,
    input  logic                      frame_ack,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic                      gp_ready,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic [NUM_QUBIT-1:0]      flag_anticommute,
    output logic                      any_anticommute,
    output logic [IDX_W-1:0]          first_idx,
    output logic [NUM_QUBIT-1:0][1:0] rd_literals,
    output logic                      rd_phase
);

    // Counter must reach NUM_QUBIT to detect the overflow row
    localparam int               CNT_W         = $clog2(NUM_QUBIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(NUM_QUBIT);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(NUM_QUBIT - 1);
    localparam logic             FIRST_IS_LAST = (NUM_QUBIT == 1);

    collect_state_t                r_state;
    collect_state_t                w_state_nxt;
    logic [CNT_W-1:0]              r_row_cnt;
    logic [NUM_QUBIT-1:0][1:0]     r_target;
    logic [NUM_QUBIT-1:0][1:0]     r_tab [NUM_QUBIT];
    logic [NUM_QUBIT-1:0]          r_flags;
    logic                          r_err;

    logic                          w_accept;
    logic                          w_clear;
    logic                          w_set_err;
    logic                          w_row_anti;
    logic [IDX_W-1:0]              w_wr_idx;
    logic [NUM_QUBIT-1:0][1:0]     w_target;

    assign w_wr_idx = r_row_cnt[IDX_W-1:0];

    // Row 0 arrives with the frame-start strobe, before the target is latched
    assign w_target = (r_state == ST_IDLE) ? pauli_target : r_target;

    pauli_row_anticommute #(
        .NUM_QUBIT (NUM_QUBIT)
    ) u_row_anti (
        .i_row         (literals_in),
        .i_target      (w_target),
        .o_anticommute (w_row_anti)
    );

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ld_flag_anticommute) begin
                    w_clear     = 1'b1;
                    w_accept    = valid_in;
                    w_state_nxt = ST_COLLECT;
                    if (valid_P) begin
                        w_state_nxt = ST_DONE;
                        w_set_err   = !(valid_in && FIRST_IS_LAST);
                    end
                end
            end
            ST_COLLECT: begin
                if (valid_in) begin
                    if (r_row_cnt == CNT_FULL) begin
                        w_set_err = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                    end
                    if (valid_P) begin
                        w_state_nxt = ST_DONE;
                        if (r_row_cnt != CNT_LAST) begin
                            w_set_err = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (frame_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            r_row_cnt <= '0;
            r_target  <= '0;
            r_flags   <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < NUM_QUBIT; i++) begin
                r_tab[i] <= '0;
            end
        end else begin
            if (w_clear) begin
                r_target <= pauli_target;
                r_flags  <= '0;
                r_err    <= w_set_err;
                for (int i = 0; i < NUM_QUBIT; i++) begin
                    r_tab[i] <= {NUM_QUBIT{LIT_I}};
                end
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_tab[w_wr_idx]   <= literals_in;
                r_flags[w_wr_idx] <= w_row_anti;
                r_row_cnt         <= r_row_cnt + CNT_W'(1);
            end else if ((r_state == ST_DONE) && frame_ack) begin
                r_row_cnt <= '0;
            end
        end
    end

`ifdef PHASE_TRACK_EN
    logic [NUM_QUBIT-1:0] r_phase;

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            r_phase <= '0;
        end else begin
            if (w_clear) begin
                r_phase <= '0;
            end
            if (w_accept) begin
                r_phase[w_wr_idx] <= phase_in;
            end
        end
    end

    assign rd_phase = r_phase[rd_idx];
`else
    logic w_unused_phase;
    assign w_unused_phase = phase_in;
    assign rd_phase       = 1'b0;
`endif

    assign gp_ready         = (r_state == ST_IDLE);
    assign frame_valid      = (r_state == ST_DONE);
    assign frame_err        = r_err;
    assign flag_anticommute = r_flags;
    assign any_anticommute  = |r_flags;
    assign rd_literals      = r_tab[rd_idx];

    always_comb begin
        first_idx = '0;
        for (int i = NUM_QUBIT - 1; i >= 0; i--) begin
            if (r_flags[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

endmodule
